// File: rtl/lcd_ctrl_param.sv
// HD44780-class character-LCD controller: power-up wait, configurable init sequence,
// then host byte transfers over an 8-bit or 4-bit panel bus with command-dependent waits.
module lcd_ctrl_param #(
  parameter int CLK_PER_US = 45,
  parameter int BUS_WIDTH  = 8,
  parameter int PWRUP_US   = 500,
  parameter int CMD_US     = 50,
  parameter int CLEAR_US   = 200,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cfg,
  input  logic       lcd_enable,
  input  logic [9:0] lcd_bus,
  output logic       busy,
  output logic       e,
  output logic       rs,
  output logic       rw,
  output logic [7:0] lcd_data,
  output logic [1:0] dbg_state
);

  localparam int MAX_A  = (PWRUP_US > CLEAR_US) ? PWRUP_US : CLEAR_US;
  localparam int MAX_US = (MAX_A > 54) ? MAX_A : 54;

  if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_bus_width
    $error("lcd_ctrl_param: BUS_WIDTH must be 8 or 4");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_US) * 64'(CLK_PER_US)) begin : g_bad_cnt_w
    $error("lcd_ctrl_param: CNT_W too small for the longest wait");
  end

  localparam logic [CNT_W-1:0] E_ON        = CNT_W'(CLK_PER_US);
  localparam logic [CNT_W-1:0] E_OFF       = CNT_W'(14 * CLK_PER_US);
  localparam logic [CNT_W-1:0] XFER_LAST   = CNT_W'(27 * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] CMD_LAST    = CNT_W'(CMD_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_US * CLK_PER_US - 1);
  localparam logic             FOUR_BIT    = (BUS_WIDTH == 4);

  typedef enum logic [1:0] {PWRUP, INIT, READY, XFER} state_t;
  typedef enum logic [1:0] {SEG_X0, SEG_X1, SEG_WAIT} seg_t;

  state_t           state_q;
  seg_t             seg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       step_q;
  logic [6:0]       cfg_q;
  logic [7:0]       byte_q;
  logic             rs_cap_q, rw_cap_q, long_q;
  logic             busy_q, e_q, rs_q, rw_q;
  logic [7:0]       data_q;

  logic             in_xfer, seg_end;
  logic             e_d, rs_d, rw_d;
  logic [7:0]       data_d;

  // Init byte for step 1..4: function set, display control, clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [2:0] step, input logic [6:0] c);
    case (step)
      3'd1:    init_byte = {3'b001, FOUR_BIT ? 1'b0 : 1'b1, c[6], c[5], 2'b00};
      3'd2:    init_byte = {5'b00001, c[4:2]};
      3'd3:    init_byte = 8'h01;
      default: init_byte = {6'b000001, c[1:0]};
    endcase
  endfunction

  function automatic logic is_long(input logic rs_v, input logic [7:0] d);
    is_long = !rs_v && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

  // Pin values are derived from the current segment/count and registered, so the
  // panel sees each transfer window one cycle after its counter position.
  always_comb begin
    in_xfer = (state_q == INIT || state_q == XFER) && seg_q != SEG_WAIT;
    e_d     = in_xfer && cnt_q >= E_ON && cnt_q < E_OFF;
    rs_d    = in_xfer && rs_cap_q;
    rw_d    = in_xfer && rw_cap_q;
    data_d  = 8'h00;
    if (in_xfer) begin
      if (FOUR_BIT) data_d = (seg_q == SEG_X0) ? {byte_q[7:4], 4'h0} : {byte_q[3:0], 4'h0};
      else          data_d = byte_q;
    end
    if (seg_q == SEG_WAIT) seg_end = (cnt_q == (long_q ? CLEAR_LAST : CMD_LAST));
    else                   seg_end = (cnt_q == XFER_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PWRUP;
      seg_q    <= SEG_X0;
      cnt_q    <= '0;
      step_q   <= 3'd0;
      cfg_q    <= 7'd0;
      byte_q   <= 8'h00;
      rs_cap_q <= 1'b0;
      rw_cap_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b1;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      e_q    <= e_d;
      rs_q   <= rs_d;
      rw_q   <= rw_d;
      data_q <= data_d;
      case (state_q)
        PWRUP: begin
          if (cnt_q == PWRUP_LAST) begin
            cnt_q    <= '0;
            cfg_q    <= cfg;
            state_q  <= INIT;
            rs_cap_q <= 1'b0;
            rw_cap_q <= 1'b0;
            long_q   <= 1'b0;
            if (FOUR_BIT) begin
              // Lone 0x2 nibble switches the panel into 4-bit mode.
              step_q <= 3'd0;
              byte_q <= 8'h02;
              seg_q  <= SEG_X1;
            end else begin
              step_q <= 3'd1;
              byte_q <= init_byte(3'd1, cfg);
              seg_q  <= SEG_X0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        READY: begin
          if (lcd_enable) begin
            state_q  <= XFER;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            seg_q    <= SEG_X0;
            rs_cap_q <= lcd_bus[9];
            rw_cap_q <= lcd_bus[8];
            byte_q   <= lcd_bus[7:0];
            long_q   <= is_long(lcd_bus[9], lcd_bus[7:0]);
          end
        end
        default: begin
          if (!seg_end) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
            case (seg_q)
              SEG_X0: seg_q <= FOUR_BIT ? SEG_X1 : SEG_WAIT;
              SEG_X1: seg_q <= SEG_WAIT;
              default: begin
                if (state_q == INIT && step_q != 3'd4) begin
                  step_q <= step_q + 3'd1;
                  byte_q <= init_byte(step_q + 3'd1, cfg_q);
                  long_q <= is_long(1'b0, init_byte(step_q + 3'd1, cfg_q));
                  seg_q  <= SEG_X0;
                end else begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign e         = e_q;
  assign rs        = rs_q;
  assign rw        = rw_q;
  assign lcd_data  = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: an 8-bit and a 4-bit instance side by side, with every
// e pulse and busy fall compared against a timeline computed from the transfer rules.
`timescale 1ns/1ps
module tb_lcd_ctrl_param;
  localparam int CPU = 2;
  localparam int PWR = 500;
  localparam int CMD = 50;
  localparam int CLR = 200;
  localparam int XW  = 27 * CPU;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cfg;
  logic       en     [2];
  logic [9:0] bus    [2];
  logic       busy_w [2];
  logic       e_w    [2];
  logic       rs_w   [2];
  logic       rw_w   [2];
  logic [7:0] data_w [2];
  logic [1:0] dbg_w  [2];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // Pulse record: {start cycle[57:26], width[25:10], rs, rw, data[7:0]}
  logic [57:0] exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

  lcd_ctrl_param #(.CLK_PER_US(CPU), .BUS_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .cfg(cfg), .lcd_enable(en[0]), .lcd_bus(bus[0]),
    .busy(busy_w[0]), .e(e_w[0]), .rs(rs_w[0]), .rw(rw_w[0]),
    .lcd_data(data_w[0]), .dbg_state(dbg_w[0]));

  lcd_ctrl_param #(.CLK_PER_US(CPU), .BUS_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .cfg(cfg), .lcd_enable(en[1]), .lcd_bus(bus[1]),
    .busy(busy_w[1]), .e(e_w[1]), .rs(rs_w[1]), .rw(rw_w[1]),
    .lcd_data(data_w[1]), .dbg_state(dbg_w[1]));

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- pulse monitor ----------------
  int         p_start [2];
  int         p_width [2];
  logic [9:0] p_bus   [2];
  logic       p_ok    [2];
  logic       e_prev  [2];

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (e_w[k] === 1'b1 && e_prev[k] !== 1'b1) begin
        p_start[k] = cyc;
        p_width[k] = 1;
        p_bus[k]   = {rs_w[k], rw_w[k], data_w[k]};
        p_ok[k]    = 1'b1;
      end else if (e_w[k] === 1'b1) begin
        p_width[k]++;
        if ({rs_w[k], rw_w[k], data_w[k]} !== p_bus[k]) p_ok[k] = 1'b0;
      end else if (e_prev[k] === 1'b1) begin
        if (k == 0) obs_q0.push_back({32'(p_start[k]), p_ok[k] ? 16'(p_width[k]) : 16'h0, p_bus[k]});
        else        obs_q1.push_back({32'(p_start[k]), p_ok[k] ? 16'(p_width[k]) : 16'h0, p_bus[k]});
      end
      e_prev[k] = e_w[k];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // One byte send starting at cycle s (first cycle after acceptance): pulses begin
  // CPU+1 cycles into each 27 us window; the send lasts its windows plus the wait.
  task automatic model_send(input int k, input int s, input logic [9:0] b, input bit nib_only,
                            output int fall);
    int nx, w;
    logic [7:0] d;
    nx = (nib_only || k == 0) ? 1 : 2;
    w  = (!nib_only && !b[9] && b[7:0] >= 8'd1 && b[7:0] <= 8'd3) ? CLR : CMD;
    for (int j = 0; j < nx; j++) begin
      if (k == 0)        d = b[7:0];
      else if (nib_only) d = {b[3:0], 4'h0};
      else               d = (j == 0) ? {b[7:4], 4'h0} : {b[3:0], 4'h0};
      if (k == 0) exp_q0.push_back({32'(s + CPU + 1 + j * XW), 16'(13 * CPU), b[9:8], d});
      else        exp_q1.push_back({32'(s + CPU + 1 + j * XW), 16'(13 * CPU), b[9:8], d});
    end
    fall = s + nx * XW + w * CPU;
  endtask

  task automatic model_init(input int k, input int c0, input logic [6:0] c, output int fall);
    logic [7:0] seq [4];
    int s;
    seq[0] = {3'b001, 1'(k == 0), c[6], c[5], 2'b00};
    seq[1] = {5'b00001, c[4:2]};
    seq[2] = 8'h01;
    seq[3] = {6'b000001, c[1:0]};
    s = c0 + PWR * CPU;
    if (k == 1) model_send(1, s, 10'h002, 1'b1, s);
    for (int i = 0; i < 4; i++) model_send(k, s, {2'b00, seq[i]}, 1'b0, s);
    fall = s;
  endtask

  task automatic compare_pulses(input int k);
    logic [57:0] ex, ob;
    int left;
    left = (k == 0) ? exp_q0.size() : exp_q1.size();
    while (left > 0) begin
      if (k == 0) ex = exp_q0.pop_front(); else ex = exp_q1.pop_front();
      if ((k == 0 ? obs_q0.size() : obs_q1.size()) == 0) begin
        check("pulse_missing", 64'(ex[57:26]), 64'hFFFF_FFFF);
      end else begin
        if (k == 0) ob = obs_q0.pop_front(); else ob = obs_q1.pop_front();
        check("pulse_start", 64'(ob[57:26]), 64'(ex[57:26]));
        check("pulse_width", 64'(ob[25:10]), 64'(ex[25:10]));
        check("pulse_bus",   64'(ob[9:0]),   64'(ex[9:0]));
      end
      left--;
    end
    check("extra_pulses", 64'(k == 0 ? obs_q0.size() : obs_q1.size()), 64'd0);
    if (k == 0) obs_q0.delete(); else obs_q1.delete();
  endtask

  // ---------------- driver tasks (all leave at 2 ns after a rising edge) ----------------
  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_w[k] !== 1'b0 && n < 5000) begin
      @(posedge clk); #2; n++;
    end
    if (busy_w[k] !== 1'b0) check("idle_timeout", 64'(busy_w[k]), 64'd0);
  endtask

  task automatic send_req(input int k, input logic [9:0] b, input int gap, input bit poke);
    int a, fall, n;
    wait_idle(k);
    repeat (gap) begin @(posedge clk); #2; end
    en[k] = 1'b1; bus[k] = b;
    @(posedge clk); #2;
    a = cyc;
    en[k] = 1'b0; bus[k] = 10'($urandom);
    check("busy_after_accept", 64'(busy_w[k]), 64'd1);
    model_send(k, a, b, 1'b0, fall);
    n = 0;
    do begin
      @(posedge clk); #2; n++;
      en[k] = poke && (n == 20);
    end while (busy_w[k] !== 1'b0 && n < 2000);
    en[k] = 1'b0;
    check("busy_fall", 64'(cyc), 64'(fall));
    if (poke) begin
      repeat (5) begin @(posedge clk); #2; end
      check("no_reaccept", 64'(busy_w[k]), 64'd0);
    end
    compare_pulses(k);
  endtask

  task automatic held_req(input int k, input logic [9:0] b, input int reps);
    int s, fall, n;
    wait_idle(k);
    en[k] = 1'b1; bus[k] = b;
    @(posedge clk); #2;
    s = cyc;
    for (int r = 0; r < reps; r++) begin
      model_send(k, s, b, 1'b0, fall);
      n = 0;
      do begin @(posedge clk); #2; n++; end
      while (busy_w[k] !== 1'b0 && n < 2000);
      check("held_fall", 64'(cyc), 64'(fall));
      if (r == reps - 1) en[k] = 1'b0;
      s = fall + 1;
    end
    @(posedge clk); #2;
    check("held_stop", 64'(busy_w[k]), 64'd0);
    compare_pulses(k);
  endtask

  task automatic reset_checks();
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 64'(busy_w[k]), 64'd1);
      check("rst_e",    64'(e_w[k]),    64'd0);
      check("rst_rs",   64'(rs_w[k]),   64'd0);
      check("rst_rw",   64'(rw_w[k]),   64'd0);
      check("rst_data", 64'(data_w[k]), 64'd0);
      check("rst_state", 64'(dbg_w[k]), 64'd0);
    end
  endtask

  task automatic run_init(input logic [6:0] c);
    int c0, n, f8, f4;
    bit d8, d4;
    cfg = c;
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    model_init(0, c0, c, f8);
    model_init(1, c0, c, f4);
    d8 = 1'b0; d4 = 1'b0; n = 0;
    while ((!d8 || !d4) && n < 6000) begin
      @(posedge clk); #2; n++;
      if (n == PWR * CPU + 10) cfg = 7'($urandom);
      if (!d8 && busy_w[0] === 1'b0) begin d8 = 1'b1; check("init_len8", 64'(cyc - c0), 64'(f8 - c0)); end
      if (!d4 && busy_w[1] === 1'b0) begin d4 = 1'b1; check("init_len4", 64'(cyc - c0), 64'(f4 - c0)); end
    end
    if (!d8 || !d4) check("init_timeout", 64'({d8, d4}), 64'd3);
    compare_pulses(0);
    compare_pulses(1);
    check("ready_state8", 64'(dbg_w[0]), 64'd2);
    check("ready_state4", 64'(dbg_w[1]), 64'd2);
  endtask

  task automatic reset_mid();
    int n = 0;
    wait_idle(0);
    en[0] = 1'b1; bus[0] = 10'h255;
    @(posedge clk); #2;
    en[0] = 1'b0;
    while (e_w[0] !== 1'b1 && n < 100) begin @(posedge clk); #2; n++; end
    check("e_before_reset", 64'(e_w[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_e",    64'(e_w[0]),    64'd0);
    check("abort_rs",   64'(rs_w[0]),   64'd0);
    check("abort_rw",   64'(rw_w[0]),   64'd0);
    check("abort_data", 64'(data_w[0]), 64'd0);
    check("abort_busy", 64'(busy_w[0]), 64'd1);
    repeat (3) begin @(posedge clk); #2; end
    exp_q0.delete(); exp_q1.delete(); obs_q0.delete(); obs_q1.delete();
    run_init(7'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] b;
    en[0] = 1'b0; en[1] = 1'b0;
    bus[0] = 10'h0; bus[1] = 10'h0;
    e_prev[0] = 1'b0; e_prev[1] = 1'b0;
    cfg = 7'b1111110;
    repeat (3) @(posedge clk);
    #2;
    reset_checks();
    run_init(7'b1111110);

    send_req(0, 10'b10_0100_0001, 0, 1'b0);
    send_req(1, 10'b10_0100_0001, 0, 1'b0);
    send_req(0, 10'h001, 3, 1'b1);
    send_req(1, 10'h002, 1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      b = 10'($urandom);
      if ($urandom_range(0, 2) == 0) b = {2'b00, 8'($urandom_range(1, 3))};
      send_req(i % 2, b, $urandom_range(0, 4), 1'b0);
    end

    held_req(0, 10'($urandom), 3);
    held_req(1, 10'($urandom), 2);

    reset_mid();
    send_req(0, 10'($urandom), 0, 1'b0);
    send_req(1, 10'($urandom), 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
